id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs valid_id (1), rs1_id, rs2_id, rd_id (5 each): decoded ID-stage instruction fields.
REQ-004 SHALL have inputs RegWrite_id, MemRead_id, MemWrite_id (1 each), ALU_op_id (4): ID-stage control.
REQ-005 SHALL have inputs rs1_data_id, rs2_data_id, imm_id, pc_id (32 each): ID-stage operands.
REQ-006 SHALL have inputs flush_ex (1), the branch/jump redirect from EX, and mem_busy (1), the MEM-stage not-ready signal.
REQ-007 SHALL have registered outputs valid_idr, rs1_idr, rs2_idr, rd_idr, RegWrite_idr, MemRead_idr, MemWrite_idr, ALU_op_idr, rs1_data_idr, rs2_data_idr, imm_idr, pc_idr, with widths matching their _id counterparts; these feed the forwarding unit and EX.
REQ-008 SHALL have combinational outputs pc_write (1), if_id_write (1), if_id_flush (1) to the front end, and state (2) for debug.

Function
REQ-009 SHALL detect a load-use hazard (lu_hz) when valid_idr & MemRead_idr & (rd_idr!=0) & valid_id & ((rd_idr==rs1_id) | (rd_idr==rs2_id)).
REQ-010 SHALL implement a three-state FSM: RUN=2'b00, BUBBLE=2'b01, HOLD=2'b10; state 2'b11 SHALL recover to RUN on the next edge.
REQ-011 In RUN with no event, each edge SHALL copy every _id input to its _idr register (latency 1), with pc_write=if_id_write=1 and if_id_flush=0.
REQ-012 In RUN with lu_hz, the edge SHALL load a bubble and go to BUBBLE, with pc_write=if_id_write=0 during that cycle.
REQ-013 A bubble SHALL set valid_idr, RegWrite_idr, MemRead_idr and MemWrite_idr to 0 and rd_idr to 0; the other _idr registers are don't-care.
REQ-014 BUBBLE SHALL last exactly one cycle, capture the held ID instruction normally, and return to RUN; lu_hz SHALL NOT be re-evaluated in BUBBLE.
REQ-015 When mem_busy=1 in RUN or BUBBLE, the next state SHALL be HOLD and all _idr registers SHALL hold; pc_write=if_id_write=0.
REQ-016 HOLD SHALL keep all _idr registers unchanged while mem_busy=1 and return to RUN on the edge where mem_busy=0, without capturing on that edge.
REQ-017 When flush_ex=1 in any state, the edge SHALL load a bubble, if_id_flush SHALL be 1 combinationally, and the next state SHALL be RUN.
REQ-018 Priority SHALL be flush_ex > mem_busy > lu_hz.
REQ-019 In HOLD, lu_hz SHALL be evaluated only after returning to RUN.
REQ-020 The block SHALL perform no arithmetic on data; data paths SHALL pass through bit-exact.

Reset
REQ-021 While rst=1, all _idr registers SHALL be 0, state SHALL be RUN, and pc_write=if_id_write=1 and if_id_flush=0, independent of clk.
REQ-022 An rst assertion mid-BUBBLE or mid-HOLD SHALL discard the stage contents, and the first edge after release SHALL capture as in RUN.

Configuration
REQ-023 With macro ID_EX_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt and flush_cnt (16 bits each, reset 0, saturating at 16'hFFFF).
REQ-024 stall_cnt SHALL increment on each edge where pc_write=0; flush_cnt SHALL increment on each edge where flush_ex=1.
REQ-025 Without ID_EX_PERF_CNT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset: assert rst mid-HOLD -> all _idr=0 and state=00 immediately; first edge after release with valid_id=1, rd_id=5 -> rd_idr=5.
REQ-027 Load-use: EX holds load rd_idr=3, MemRead_idr=1; ID has rs2_id=3 -> one cycle with pc_write=0 and valid_idr=0; next edge rs2_idr=3, valid_idr=1.
REQ-028 Load to x0: rd_idr=0, MemRead_idr=1, rs1_id=0 -> no stall, pc_write=1 throughout.
REQ-029 Flush vs hazard: lu_hz and flush_ex=1 in the same cycle -> if_id_flush=1, bubble loaded, state=RUN, no BUBBLE cycle.
REQ-030 Hold: mem_busy=1 for 3 cycles with rs1_data_id changing -> rs1_data_idr stays at its pre-hold value (e.g. 32'hDEADBEEF) for 3 cycles; RUN on the 4th edge.
REQ-031 Counters (ID_EX_PERF_CNT_EN): 2 load-use stalls and 1 flush -> stall_cnt=2, flush_cnt=1; force stall_cnt=16'hFFFF and stall once more -> remains 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use, MEM back-pressure and flush control.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [4:0]  rd_id,
    input  logic        RegWrite_id,
    input  logic        MemRead_id,
    input  logic        MemWrite_id,
    input  logic [3:0]  ALU_op_id,
    input  logic [31:0] rs1_data_id,
    input  logic [31:0] rs2_data_id,
    input  logic [31:0] imm_id,
    input  logic [31:0] pc_id,
    input  logic        flush_ex,
    input  logic        mem_busy,
    output logic        valid_idr,
    output logic [4:0]  rs1_idr,
    output logic [4:0]  rs2_idr,
    output logic [4:0]  rd_idr,
    output logic        RegWrite_idr,
    output logic        MemRead_idr,
    output logic        MemWrite_idr,
    output logic [3:0]  ALU_op_idr,
    output logic [31:0] rs1_data_idr,
    output logic [31:0] rs2_data_idr,
    output logic [31:0] imm_idr,
    output logic [31:0] pc_idr,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic [1:0]  state
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BUBBLE  = 2'b01,
        HOLD    = 2'b10,
        RECOVER = 2'b11
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  alu_op;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
    } stage_t;

    state_e state_q, state_d;
    stage_t stage_q, stage_d;
    stage_t id_in;
    logic   lu_hz;
    logic   capture;
    logic   bubble;
    logic   stall;

    always_comb begin
        id_in = {valid_id, rs1_id, rs2_id, rd_id, RegWrite_id, MemRead_id,
                 MemWrite_id, ALU_op_id, rs1_data_id, rs2_data_id, imm_id, pc_id};
    end

    always_comb begin
        lu_hz = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & valid_id &
                ((stage_q.rd == rs1_id) | (stage_q.rd == rs2_id));
    end

    // Priority: flush_ex, then mem_busy, then load-use (RUN only).
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        bubble  = 1'b0;
        stall   = 1'b0;
        if (flush_ex) begin
            bubble  = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        stall   = 1'b1;
                        state_d = HOLD;
                    end else if (lu_hz) begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        state_d = BUBBLE;
                    end else begin
                        capture = 1'b1;
                    end
                end
                BUBBLE: begin
                    if (mem_busy) begin
                        stall   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        capture = 1'b1;
                        state_d = RUN;
                    end
                end
                HOLD: begin
                    // The exit edge must not capture, so the front end stays frozen too.
                    stall = 1'b1;
                    if (!mem_busy) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (capture) begin
            stage_d = id_in;
        end else if (bubble) begin
            stage_d           = id_in;
            stage_d.valid     = 1'b0;
            stage_d.rd        = 5'd0;
            stage_d.reg_write = 1'b0;
            stage_d.mem_read  = 1'b0;
            stage_d.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        pc_write     = rst | ~stall;
        if_id_write  = rst | ~stall;
        if_id_flush  = ~rst & flush_ex;
        state        = state_q;
        valid_idr    = stage_q.valid;
        rs1_idr      = stage_q.rs1;
        rs2_idr      = stage_q.rs2;
        rd_idr       = stage_q.rd;
        RegWrite_idr = stage_q.reg_write;
        MemRead_idr  = stage_q.mem_read;
        MemWrite_idr = stage_q.mem_write;
        ALU_op_idr   = stage_q.alu_op;
        rs1_data_idr = stage_q.rs1_data;
        rs2_data_idr = stage_q.rs2_data;
        imm_idr      = stage_q.imm;
        pc_idr       = stage_q.pc;
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush_ex && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table with a one-deep scoreboard,
// plus directed reset-in-HOLD and (with ID_EX_PERF_CNT_EN) counter sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_id;
    logic [4:0]  rs1_id, rs2_id, rd_id;
    logic        RegWrite_id, MemRead_id, MemWrite_id;
    logic [3:0]  ALU_op_id;
    logic [31:0] rs1_data_id, rs2_data_id, imm_id, pc_id;
    logic        flush_ex, mem_busy;
    logic        valid_idr;
    logic [4:0]  rs1_idr, rs2_idr, rd_idr;
    logic        RegWrite_idr, MemRead_idr, MemWrite_idr;
    logic [3:0]  ALU_op_idr;
    logic [31:0] rs1_data_idr, rs2_data_idr, imm_idr, pc_idr;
    logic        pc_write, if_id_write, if_id_flush;
    logic [1:0]  state;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
        .ALU_op_id(ALU_op_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
        .imm_id(imm_id), .pc_id(pc_id), .flush_ex(flush_ex), .mem_busy(mem_busy),
        .valid_idr(valid_idr), .rs1_idr(rs1_idr), .rs2_idr(rs2_idr), .rd_idr(rd_idr),
        .RegWrite_idr(RegWrite_idr), .MemRead_idr(MemRead_idr), .MemWrite_idr(MemWrite_idr),
        .ALU_op_idr(ALU_op_idr), .rs1_data_idr(rs1_data_idr), .rs2_data_idr(rs2_data_idr),
        .imm_idr(imm_idr), .pc_idr(pc_idr), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .state(state)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw;
        logic [3:0]  alu;
        logic [31:0] d1;
        logic        fl, busy;
        logic        e_pcw, e_fl;
        logic [1:0]  e_st;
        logic        e_v;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic        e_rw, e_mr, e_mw;
        logic [3:0]  e_alu;
        logic [31:0] e_d1;
        logic        chk;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;
    vec_t tbl[22];
    vec_t sb[$];
    int   sb_idx[$];

    function automatic logic [31:0] d2f(input logic [31:0] d);
        return ~d;
    endfunction
    function automatic logic [31:0] immf(input logic [31:0] d);
        return d ^ 32'h5A5A5A5A;
    endfunction
    function automatic logic [31:0] pcf(input logic [31:0] d);
        return {d[15:0], d[31:16]};
    endfunction

    function automatic vec_t mk(input int v, r1, r2, rd, rw, mr, mw, alu, input logic [31:0] d1,
                                input int fl, bz, pcw, efl, st, ev, er1, er2, erd, erw, emr, emw,
                                ealu, input logic [31:0] ed1, input int ck);
        vec_t m;
        m.v = v[0]; m.rs1 = r1[4:0]; m.rs2 = r2[4:0]; m.rd = rd[4:0];
        m.rw = rw[0]; m.mr = mr[0]; m.mw = mw[0]; m.alu = alu[3:0]; m.d1 = d1;
        m.fl = fl[0]; m.busy = bz[0]; m.e_pcw = pcw[0]; m.e_fl = efl[0]; m.e_st = st[1:0];
        m.e_v = ev[0]; m.e_rs1 = er1[4:0]; m.e_rs2 = er2[4:0]; m.e_rd = erd[4:0];
        m.e_rw = erw[0]; m.e_mr = emr[0]; m.e_mw = emw[0]; m.e_alu = ealu[3:0];
        m.e_d1 = ed1; m.chk = ck[0];
        return m;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_in(input vec_t t);
        valid_id = t.v; rs1_id = t.rs1; rs2_id = t.rs2; rd_id = t.rd;
        RegWrite_id = t.rw; MemRead_id = t.mr; MemWrite_id = t.mw; ALU_op_id = t.alu;
        rs1_data_id = t.d1; rs2_data_id = d2f(t.d1); imm_id = immf(t.d1); pc_id = pcf(t.d1);
        flush_ex = t.fl; mem_busy = t.busy;
    endtask

    task automatic check_regs(input vec_t e, input int idx);
        chk($sformatf("v%0d_ctrl", idx),
            128'({state, valid_idr, rd_idr, RegWrite_idr, MemRead_idr, MemWrite_idr}),
            128'({e.e_st, e.e_v, e.e_rd, e.e_rw, e.e_mr, e.e_mw}));
        if (e.chk) begin
            chk($sformatf("v%0d_ids", idx), 128'({rs1_idr, rs2_idr, ALU_op_idr, rs1_data_idr}),
                128'({e.e_rs1, e.e_rs2, e.e_alu, e.e_d1}));
            chk($sformatf("v%0d_data", idx), 128'({rs2_data_idr, imm_idr, pc_idr}),
                128'({d2f(e.e_d1), immf(e.e_d1), pcf(e.e_d1)}));
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] r1, r2, d, input logic mr, fl, bz);
        valid_id = v; rs1_id = r1; rs2_id = r2; rd_id = d;
        RegWrite_id = 1'b1; MemRead_id = mr; MemWrite_id = 1'b0; ALU_op_id = 4'd0;
        rs1_data_id = '0; rs2_data_id = '0; imm_id = '0; pc_id = '0;
        flush_ex = fl; mem_busy = bz;
        @(negedge clk);
    endtask

    initial begin
        //          v rs1 rs2 rd rw mr mw alu d1            fl bz | pcw fl st ev er1 er2 erd rw mr mw alu ed1       ck
        tbl[0]  = mk(1, 1, 2, 5, 1, 0, 0, 3, 32'h11111111, 0, 0, 1, 0, 0, 1, 1, 2, 5, 1, 0, 0, 3, 32'h11111111, 1);
        tbl[1]  = mk(1, 6, 7, 3, 1, 1, 0, 0, 32'h22222222, 0, 0, 1, 0, 0, 1, 6, 7, 3, 1, 1, 0, 0, 32'h22222222, 1);
        tbl[2]  = mk(1, 8, 3, 9, 1, 0, 0, 2, 32'h33333333, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        tbl[3]  = mk(1, 8, 3, 9, 1, 0, 0, 2, 32'h33333333, 0, 0, 1, 0, 0, 1, 8, 3, 9, 1, 0, 0, 2, 32'h33333333, 1);
        tbl[4]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 32'h44444444, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h44444444, 1);
        tbl[5]  = mk(1, 0, 4, 10, 1, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 0, 1, 0, 4, 10, 1, 0, 0, 1, 32'hDEADBEEF, 1);
        tbl[6]  = mk(1, 11, 12, 13, 1, 0, 0, 4, 32'hAAAAAAAA, 0, 1, 0, 0, 2, 1, 0, 4, 10, 1, 0, 0, 1, 32'hDEADBEEF, 1);
        tbl[7]  = mk(1, 11, 12, 13, 1, 0, 0, 4, 32'hBBBBBBBB, 0, 1, 0, 0, 2, 1, 0, 4, 10, 1, 0, 0, 1, 32'hDEADBEEF, 1);
        tbl[8]  = mk(1, 11, 12, 13, 1, 0, 0, 4, 32'hCCCCCCCC, 0, 1, 0, 0, 2, 1, 0, 4, 10, 1, 0, 0, 1, 32'hDEADBEEF, 1);
        tbl[9]  = mk(1, 11, 12, 13, 1, 0, 0, 4, 32'hCCCCCCCC, 0, 0, 0, 0, 0, 1, 0, 4, 10, 1, 0, 0, 1, 32'hDEADBEEF, 1);
        tbl[10] = mk(1, 11, 12, 13, 1, 0, 0, 4, 32'hCCCCCCCC, 0, 0, 1, 0, 0, 1, 11, 12, 13, 1, 0, 0, 4, 32'hCCCCCCCC, 1);
        tbl[11] = mk(1, 1, 1, 7, 1, 1, 0, 0, 32'h12345678, 0, 0, 1, 0, 0, 1, 1, 1, 7, 1, 1, 0, 0, 32'h12345678, 1);
        tbl[12] = mk(1, 7, 2, 8, 1, 0, 0, 5, 32'h87654321, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        tbl[13] = mk(1, 1, 2, 4, 1, 1, 0, 0, 32'h0F0F0F0F, 0, 0, 1, 0, 0, 1, 1, 2, 4, 1, 1, 0, 0, 32'h0F0F0F0F, 1);
        tbl[14] = mk(1, 4, 0, 6, 1, 0, 0, 7, 32'hF0F0F0F0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        tbl[15] = mk(1, 4, 0, 6, 1, 0, 0, 7, 32'hF0F0F0F0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        tbl[16] = mk(1, 4, 0, 6, 1, 0, 0, 7, 32'hF0F0F0F0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        tbl[17] = mk(1, 3, 5, 31, 0, 0, 1, 15, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 3, 5, 31, 0, 0, 1, 15, 32'hFFFFFFFF, 1);
        tbl[18] = mk(0, 7, 8, 9, 1, 1, 0, 6, 32'h00000001, 0, 0, 1, 0, 0, 0, 7, 8, 9, 1, 1, 0, 6, 32'h00000001, 1);
        tbl[19] = mk(1, 9, 9, 2, 1, 0, 0, 1, 32'h00000002, 0, 0, 1, 0, 0, 1, 9, 9, 2, 1, 0, 0, 1, 32'h00000002, 1);
        tbl[20] = mk(1, 1, 1, 12, 1, 1, 0, 0, 32'h00000003, 0, 0, 1, 0, 0, 1, 1, 1, 12, 1, 1, 0, 0, 32'h00000003, 1);
        tbl[21] = mk(0, 12, 12, 1, 0, 0, 0, 0, 32'h00000004, 0, 0, 1, 0, 0, 0, 12, 12, 1, 0, 0, 0, 0, 32'h00000004, 1);

        // Reset with hostile inputs: outputs must still show the reset values.
        rst = 1'b1;
        drive_in(tbl[12]);
        flush_ex = 1'b1;
        mem_busy = 1'b1;
        #12;
        chk("rst_regs", 128'({valid_idr, rd_idr, rs1_idr, MemRead_idr, rs1_data_idr, pc_idr}), 128'(0));
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_comb", 128'({pc_write, if_id_write, if_id_flush}), 128'(3'b110));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive_in(tbl[i]);
            #1;
            chk($sformatf("v%0d_comb", i), 128'({pc_write, if_id_write, if_id_flush}),
                128'({tbl[i].e_pcw, tbl[i].e_pcw, tbl[i].e_fl}));
            sb.push_back(tbl[i]);
            sb_idx.push_back(i);
            @(negedge clk);
            if (sb.size() > 0) check_regs(sb.pop_front(), sb_idx.pop_front());
        end

        // Asynchronous reset while in HOLD.
        cyc(1'b1, 5'd2, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1);
        chk("hold_entry_state", 128'(state), 128'(2));
        rst = 1'b1;
        #1;
        chk("rst_hold_state", 128'(state), 128'(0));
        chk("rst_hold_regs", 128'({valid_idr, rd_idr, rs1_idr, rs1_data_idr}), 128'(0));
        chk("rst_hold_pcw", 128'({pc_write, if_id_write}), 128'(2'b11));
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("post_rst_capture", 128'({state, valid_idr, rd_idr}), 128'({2'b00, 1'b1, 5'd5}));

`ifdef ID_EX_PERF_CNT_EN
        rst = 1'b1;
        #1;
        chk("cnt_rst", 128'({stall_cnt, flush_cnt}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0);
        chk("cnt_stall", 128'(stall_cnt), 128'(2));
        chk("cnt_flush", 128'(flush_cnt), 128'(1));
        force dut.stall_cnt_q = 16'hFFFF;
        cyc(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        release dut.stall_cnt_q;
        cyc(1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        chk("cnt_stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
        chk("cnt_flush_keep", 128'(flush_cnt), 128'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
